// File: rtl/csense_adc_pkg.sv
// Shared constants for the capacitive-sense ADC scan sequencer: register map,
// CTRL/STATUS bit positions, FSM states and frame timing in SCLK half-periods.
package csense_adc_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_MASK   = 4'd1;
  localparam logic [3:0] ADDR_STATUS = 4'd2;
  localparam logic [3:0] ADDR_RES0   = 4'd8;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_START = 1;
  localparam int CTRL_BUSY  = 2;
  localparam int CTRL_IRQEN = 3;
  localparam int STAT_DONE  = 0;
  localparam int RES_VALID  = 31;

  localparam int FRAME_BITS = 16;
  localparam int SETUP_HP   = 1;
  localparam int SHIFT_HP   = 32;
  localparam int GAP_HP     = 2;
  localparam int FRAME_HP   = SETUP_HP + SHIFT_HP + GAP_HP;
  localparam int CH_LSB     = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    lowest_ch = '0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) lowest_ch = 3'(i);
  endfunction

endpackage

// File: rtl/csense_adc_spi_frame.sv
// One 16-bit SPI frame: SCLK starts low on i_start, MOSI changes on falling
// edges (MSB first), MISO sampled on rising edges; SCLK is left high at the end.
module csense_adc_spi_frame
  import csense_adc_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic [15:0] i_tx,
  input  logic        i_miso,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic [15:0] o_rx,
  output logic        o_frame_done
);

  localparam int DW = $clog2(SCLK_DIV);

  logic          r_act;
  logic [DW-1:0] r_div;
  logic [4:0]    r_hp;
  logic [15:0]   r_tx;
  logic [15:0]   r_rx;
  logic          r_sclk;
  logic          r_mosi;
  logic          w_tick;

  assign w_tick       = r_act && (r_div == DW'(SCLK_DIV - 1));
  assign o_frame_done = w_tick && (r_hp == 5'(SHIFT_HP - 1));
  assign o_sclk       = r_sclk;
  assign o_mosi       = r_mosi;
  assign o_rx         = r_rx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act  <= 1'b0;
      r_div  <= '0;
      r_hp   <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_sclk <= 1'b1;
      r_mosi <= 1'b0;
    end else if (i_start) begin
      r_act  <= 1'b1;
      r_div  <= '0;
      r_hp   <= '0;
      r_sclk <= 1'b0;
      r_mosi <= i_tx[15];
      r_tx   <= {i_tx[14:0], 1'b0};
    end else if (r_act) begin
      if (w_tick) begin
        r_div <= '0;
        r_hp  <= r_hp + 5'd1;
        if (!r_hp[0]) begin
          r_sclk <= 1'b1;
          r_rx   <= {r_rx[14:0], i_miso};
        end else if (r_hp == 5'(SHIFT_HP - 1)) begin
          // last half-period: park SCLK high and release MOSI
          r_act  <= 1'b0;
          r_mosi <= 1'b0;
        end else begin
          r_sclk <= 1'b0;
          r_mosi <= r_tx[15];
          r_tx   <= {r_tx[14:0], 1'b0};
        end
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

endmodule

// File: rtl/csense_adc_seq.sv
// Avalon-MM controlled ADC channel scanner with result registers.
// Optional irq output enabled by defining CSENSE_ADC_SEQ_IRQ_EN.
module csense_adc_seq
  import csense_adc_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int SCLK_DIV = 4,
  parameter int DATA_W   = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_mosi,
  input  logic        adc_miso
`ifdef CSENSE_ADC_SEQ_IRQ_EN
  ,output logic       irq
`endif
);

  localparam int CW = $clog2(GAP_HP * SCLK_DIV) + 1;

  state_t                         r_state, w_nxt;
  logic [CW-1:0]                  r_cnt;
  logic                           r_en;
  logic                           r_done;
  logic [NUM_CH-1:0]              r_mask;
  logic [NUM_CH-1:0]              r_pend;
  logic [2:0]                     r_cur_ch;
  logic [2:0]                     r_prev_ch;
  logic                           r_last;
  logic                           r_first;
  logic                           r_prev_vld;
  logic                           r_wr_pend;
  logic [NUM_CH-1:0][DATA_W-1:0]  r_res;
  logic [NUM_CH-1:0]              r_res_vld;

  logic                           w_wr;
  logic                           w_scan;
  logic [7:0]                     w_pend8;
  logic                           w_empty;
  logic [2:0]                     w_ch;
  logic [NUM_CH-1:0]              w_clr;
  logic [15:0]                    w_tx;
  logic [15:0]                    w_rx;
  logic                           w_setup_end;
  logic                           w_gap_end;
  logic                           w_frame_done;
  logic                           w_busy;
  logic                           w_unused;

  assign w_wr        = chipselect && !write_n;
  assign w_scan      = ((w_wr && address == ADDR_CTRL && writedata[CTRL_START]) || r_en)
                       && (|r_mask);
  assign w_empty     = ~|r_pend;
  assign w_ch        = w_empty ? 3'd0 : lowest_ch(w_pend8);
  assign w_clr       = NUM_CH'(1) << w_ch;
  assign w_tx        = {2'b00, w_ch, 11'd0};
  assign w_setup_end = (r_state == S_SETUP) && (r_cnt == CW'(SETUP_HP * SCLK_DIV - 1));
  assign w_gap_end   = (r_state == S_GAP) && (r_cnt == CW'(GAP_HP * SCLK_DIV - 1));
  assign w_busy      = (r_state != S_IDLE);
  assign adc_cs_n    = !((r_state == S_SETUP) || (r_state == S_SHIFT));
  assign w_unused    = ^{writedata, w_rx};

  always_comb begin
    w_pend8 = '0;
    w_pend8[NUM_CH-1:0] = r_pend;
  end

  csense_adc_spi_frame #(.SCLK_DIV(SCLK_DIV)) u_frame (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (w_setup_end),
    .i_tx         (w_tx),
    .i_miso       (adc_miso),
    .o_sclk       (adc_sclk),
    .o_mosi       (adc_mosi),
    .o_rx         (w_rx),
    .o_frame_done (w_frame_done)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_scan)       w_nxt = S_SETUP;
      S_SETUP: if (w_setup_end)  w_nxt = S_SHIFT;
      S_SHIFT: if (w_frame_done) w_nxt = S_GAP;
      S_GAP:   if (w_gap_end)    w_nxt = r_last ? S_DONE : S_SETUP;
      S_DONE:                    w_nxt = S_IDLE;
      default:                   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? '0 : r_cnt + CW'(1);
    end
  end

  // Channel bookkeeping: the frame sent now returns data for the previous frame's channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend     <= '0;
      r_cur_ch   <= '0;
      r_prev_ch  <= '0;
      r_last     <= 1'b0;
      r_first    <= 1'b0;
      r_prev_vld <= 1'b0;
      r_wr_pend  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_scan) begin
        r_pend  <= r_mask;
        r_first <= 1'b1;
      end
      if (w_setup_end) begin
        r_cur_ch   <= w_ch;
        r_last     <= w_empty;
        r_prev_ch  <= r_cur_ch;
        r_prev_vld <= !r_first;
        r_first    <= 1'b0;
        r_pend     <= r_pend & ~w_clr;
      end
      r_wr_pend <= (r_state == S_SHIFT) && w_frame_done && r_prev_vld;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_res     <= '0;
      r_res_vld <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_wr_pend && r_prev_ch == 3'(i)) begin
          r_res[i]     <= w_rx[DATA_W-1:0];
          r_res_vld[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en   <= 1'b0;
      r_mask <= '1;
      r_done <= 1'b0;
    end else begin
      if (w_wr && address == ADDR_CTRL) r_en   <= writedata[CTRL_EN];
      if (w_wr && address == ADDR_MASK) r_mask <= writedata[NUM_CH-1:0];
      if (r_state == S_DONE)
        r_done <= 1'b1;
      else if (w_wr && address == ADDR_STATUS && writedata[STAT_DONE])
        r_done <= 1'b0;
    end
  end

`ifdef CSENSE_ADC_SEQ_IRQ_EN
  logic r_irq_en;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_irq_en <= 1'b0;
    else if (w_wr && address == ADDR_CTRL) r_irq_en <= writedata[CTRL_IRQEN];
  end
  assign irq = r_done && r_irq_en;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_EN]   = r_en;
        readdata[CTRL_BUSY] = w_busy;
`ifdef CSENSE_ADC_SEQ_IRQ_EN
        readdata[CTRL_IRQEN] = r_irq_en;
`endif
      end
      ADDR_MASK:   readdata[NUM_CH-1:0] = r_mask;
      ADDR_STATUS: readdata[STAT_DONE]  = r_done;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (address == ADDR_RES0 + 4'(i)) begin
            readdata[DATA_W-1:0] = r_res[i];
            readdata[RES_VALID]  = r_res_vld[i];
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_csense_adc_seq.sv
// Directed bench for csense_adc_seq with a behavioural SPI ADC that returns a
// fixed per-channel value one frame after its channel address is received.
module tb_csense_adc_seq;

  localparam int NUM_CH = 8, SCLK_DIV = 4, DATA_W = 12;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        adc_cs_n, adc_sclk, adc_mosi;
  logic        adc_miso = 1'b0;
`ifdef CSENSE_ADC_SEQ_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csense_adc_seq #(.NUM_CH(NUM_CH), .SCLK_DIV(SCLK_DIV), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .adc_mosi   (adc_mosi),
    .adc_miso   (adc_miso)
`ifdef CSENSE_ADC_SEQ_IRQ_EN
    ,.irq       (irq)
`endif
  );

  // ADC model
  logic [11:0] adc_val [8] = '{12'h123, 12'h456, 12'h789, 12'hABC,
                               12'hDEF, 12'h321, 12'h654, 12'h987};
  logic [15:0] m_rx_sh = '0;
  logic [15:0] m_word  = 16'hFFFF;
  int          m_rcnt  = 0;
  logic [15:0] sent_w [$];

  always @(negedge adc_cs_n) m_rcnt = 0;
  always @(posedge adc_sclk) if (adc_cs_n === 1'b0) begin
    m_rx_sh = {m_rx_sh[14:0], adc_mosi};
    m_rcnt++;
  end
  always @(negedge adc_sclk) if (adc_cs_n === 1'b0 && m_rcnt < 16) adc_miso = m_word[15-m_rcnt];
  always @(posedge adc_cs_n) if (reset_n === 1'b1) begin
    sent_w.push_back(m_rx_sh);
    m_word = {4'hF, adc_val[m_rx_sh[13:11]]};
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    logic [3:0]  a_tab [6] = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd15, 4'd3};
    logic [31:0] e_tab [6] = '{32'h0, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h0};
    #2 reset_n = 1'b0;
    #2;
    checks++;
    if ({adc_cs_n, adc_sclk, adc_mosi} !== 3'b110) begin
      errors++; $display("FAIL reset_pins: got %b expected 110", {adc_cs_n, adc_sclk, adc_mosi});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      rd(a_tab[i], v);
      checks++;
      if (v !== e_tab[i]) begin
        errors++; $display("FAIL reset_reg%0d: got %h expected %h", a_tab[i], v, e_tab[i]);
      end
    end
  endtask

  task automatic test_mask_zero;
    logic [31:0] v;
    int cs_low = 0;
    sent_w.delete();
    wr(4'd1, 32'h0);
    wr(4'd0, 32'h2);
    repeat (20) begin @(negedge clk); if (adc_cs_n !== 1'b1) cs_low++; end
    wr(4'd0, 32'h1);
    repeat (20) begin @(negedge clk); if (adc_cs_n !== 1'b1) cs_low++; end
    rd(4'd0, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL mask0_ctrl: got %h expected 00000001", v); end
    wr(4'd0, 32'h0);
    checks++;
    if (cs_low != 0) begin errors++; $display("FAIL mask0_cs: got %0d low cycles expected 0", cs_low); end
    rd(4'd2, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL mask0_done: got %h expected 0", v); end
    checks++;
    if (sent_w.size() != 0) begin errors++; $display("FAIL mask0_frames: got %0d expected 0", sent_w.size()); end
  endtask

  task automatic test_scan;
    logic [31:0] v, s;
    int done_n = 0;
    logic [15:0] exp_w [3] = '{16'h0000, 16'h1000, 16'h0000};
    logic [15:0] g;
    sent_w.delete();
    wr(4'd1, 32'h5);
    wr(4'd0, 32'h2);
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      rd(4'd2, s);
      if (n == 200) begin
        rd(4'd0, v); checks++;
        if (v !== 32'h4) begin errors++; $display("FAIL scan_busy: got %h expected 00000004", v); end
      end
      if (n == 272) begin
        rd(4'd8, v); checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL scan_res0_early: got %h expected 0", v); end
      end
      if (n == 273) begin
        rd(4'd8, v); checks++;
        if (v !== 32'h8000_0123) begin errors++; $display("FAIL scan_res0_update: got %h expected 80000123", v); end
      end
      if (s[0] === 1'b1) begin done_n = n; break; end
    end
    checks++;
    if (done_n != 421) begin errors++; $display("FAIL scan_done_time: got %0d expected 421", done_n); end
    checks++;
    if (sent_w.size() != 3) begin errors++; $display("FAIL scan_frames: got %0d expected 3", sent_w.size()); end
    for (int i = 0; i < 3; i++) begin
      g = (i < sent_w.size()) ? sent_w[i] : 16'hxxxx;
      checks++;
      if (g !== exp_w[i]) begin errors++; $display("FAIL scan_mosi%0d: got %h expected %h", i, g, exp_w[i]); end
    end
    rd(4'd8, v); checks++;
    if (v !== 32'h8000_0123) begin errors++; $display("FAIL scan_res0: got %h expected 80000123", v); end
    rd(4'd10, v); checks++;
    if (v !== 32'h8000_0789) begin errors++; $display("FAIL scan_res2: got %h expected 80000789", v); end
    rd(4'd9, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL scan_res1: got %h expected 0", v); end
    rd(4'd0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL scan_idle: got %h expected 0", v); end
  endtask

  task automatic test_done_clear;
    logic [31:0] v;
    wr(4'd2, 32'h1);
    rd(4'd2, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL w1c: got %h expected 0", v); end
    wr(4'd0, 32'h2);
    repeat (420) @(negedge clk);
    rd(4'd2, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL pre_done: got %h expected 0", v); end
    address = 4'd2; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    rd(4'd2, v); checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL set_beats_clear: got %h expected 1", v); end
    wr(4'd2, 32'h1);
    rd(4'd2, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL clear_after: got %h expected 0", v); end
  endtask

  task automatic test_enable;
    logic [31:0] v, s;
    int found = 0, cs_low = 0;
    wr(4'd2, 32'h1);
    wr(4'd1, 32'h1);
    wr(4'd0, 32'h1);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); rd(4'd2, s);
      if (s[0] === 1'b1) begin found = 1; break; end
    end
    checks++;
    if (found != 1) begin errors++; $display("FAIL en_done1: got %0d expected 1", found); end
    rd(4'd0, v); checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL en_idle_cycle: got %h expected 00000001", v); end
    @(negedge clk);
    rd(4'd0, v); checks++;
    if (v !== 32'h5) begin errors++; $display("FAIL en_restart: got %h expected 00000005", v); end
    wr(4'd2, 32'h1);
    repeat (100) @(negedge clk);
    wr(4'd0, 32'h0);
    found = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); rd(4'd2, s);
      if (s[0] === 1'b1) begin found = 1; break; end
    end
    checks++;
    if (found != 1) begin errors++; $display("FAIL en_done2: got %0d expected 1", found); end
    repeat (300) begin @(negedge clk); if (adc_cs_n !== 1'b1) cs_low++; end
    checks++;
    if (cs_low != 0) begin errors++; $display("FAIL en_stops: got %0d low cycles expected 0", cs_low); end
    rd(4'd0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL en_ctrl_idle: got %h expected 0", v); end
    rd(4'd8, v); checks++;
    if (v !== 32'h8000_0123) begin errors++; $display("FAIL en_res0: got %h expected 80000123", v); end
  endtask

`ifdef CSENSE_ADC_SEQ_IRQ_EN
  task automatic test_irq;
    logic [31:0] v, s;
    int found = 0;
    wr(4'd2, 32'h1);
    wr(4'd1, 32'h1);
    wr(4'd0, 32'hA);
    rd(4'd0, v); checks++;
    if (v !== 32'hC) begin errors++; $display("FAIL irq_ctrl: got %h expected 0000000c", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); rd(4'd2, s);
      if (s[0] === 1'b1) begin found = 1; break; end
    end
    checks++;
    if (found != 1 || irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b expected 1", irq); end
    wr(4'd2, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
    wr(4'd0, 32'h0);
  endtask
`endif

  task automatic test_reset_mid;
    logic [31:0] v;
    int ok = 0;
    wr(4'd1, 32'h5);
    wr(4'd0, 32'h2);
    repeat (30) @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #2;
      if (adc_sclk === 1'b0 && adc_cs_n === 1'b0) begin ok = 1; break; end
    end
    checks++;
    if (ok != 1) begin errors++; $display("FAIL rst_mid_shift: got %0d expected 1", ok); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({adc_cs_n, adc_sclk, adc_mosi} !== 3'b110) begin
      errors++; $display("FAIL rst_mid_pins: got %b expected 110", {adc_cs_n, adc_sclk, adc_mosi});
    end
    @(negedge clk);
    reset_n = 1'b1;
    rd(4'd8, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL rst_mid_res0: got %h expected 0", v); end
    rd(4'd10, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL rst_mid_res2: got %h expected 0", v); end
    rd(4'd1, v); checks++;
    if (v !== 32'hFF) begin errors++; $display("FAIL rst_mid_mask: got %h expected ff", v); end
    repeat (50) @(negedge clk);
    checks++;
    if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got %b expected 1", adc_cs_n); end
  endtask

  initial begin
    test_reset();
    test_mask_zero();
    test_scan();
    test_done_clear();
    test_enable();
`ifdef CSENSE_ADC_SEQ_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
